dmem_arbiter: RTL and testbench

Shares the single data memory port (`data_mem`: 8 x 16-bit, synchronous write, combinational read) between the processor's memory stage and a debug/loader requester. The CPU has fixed priority, a starvation counter guarantees debug progress, and debug may lock the port for bursts. When the CPU loses arbitration the block raises `pipe_stall` to freeze the pipeline. It sits between the stage-3/4 pipeline registers and `data_mem`.

---
 rtl/proc_pkg.sv | 13 +
 rtl/rd_capture.sv | 26 ++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: default data-path widths and the data-memory
// arbiter state encoding.
package proc_pkg;

    localparam int DW = 16;
    localparam int AW = 3;

    typedef enum logic {
        ST_ARB      = 1'b0,
        ST_DBG_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rd_capture.sv
// Per-requester read-return register: latches memory read data on a granted
// read and pulses rvalid for the following cycle.
module rd_capture #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          capture,
    input  logic [DW-1:0] data,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);

    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= capture;
            if (capture) rdata <= data;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the CPU memory stage and a
// debug/loader requester, with starvation protection and debug lock bursts.
module dmem_arbiter
    import proc_pkg::*;
#(
    parameter int DW         = proc_pkg::DW,
    parameter int AW         = proc_pkg::AW,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_lock,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          pipe_stall
);

    arb_state_e state, state_nxt;
    logic [3:0] starve_cnt;
    logic       starved;
    logic       arb_cpu, arb_dbg;

    assign starved = (starve_cnt == 4'(STARVE_MAX));

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        arb_cpu   = 1'b0;
        arb_dbg   = 1'b0;
        state_nxt = state;
        unique case (state)
            ST_ARB: begin
                if (dbg_req && starved) arb_dbg = 1'b1;
                else if (cpu_req)       arb_cpu = 1'b1;
                else if (dbg_req)       arb_dbg = 1'b1;
                if (arb_dbg && dbg_lock) state_nxt = ST_DBG_LOCK;
            end
            ST_DBG_LOCK: begin
                arb_dbg = dbg_req;
                if (!dbg_lock || !dbg_req) state_nxt = ST_ARB;
            end
            default: state_nxt = ST_ARB;
        endcase
    end

    // Reset masks the grants combinationally so nothing reaches memory while held.
    assign cpu_gnt    = arb_cpu & rst_n;
    assign dbg_gnt    = arb_dbg & rst_n;
    assign pipe_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ARB;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (dbg_gnt)
                starve_cnt <= '0;
            else if (dbg_req && !starved)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    rd_capture #(.DW(DW)) u_cpu_rd (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (cpu_gnt & ~cpu_we),
        .data    (mem_rdata),
        .rvalid  (cpu_rvalid),
        .rdata   (cpu_rdata)
    );

    rd_capture #(.DW(DW)) u_dbg_rd (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (dbg_gnt & ~dbg_we),
        .data    (mem_rdata),
        .rvalid  (dbg_rvalid),
        .rdata   (dbg_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 8 x 16 data memory.
module tb_dmem_arbiter;
    import proc_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [2:0]    cpu_addr;
    logic [15:0]   cpu_wdata, cpu_rdata;
    logic          dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
    logic [2:0]    dbg_addr;
    logic [15:0]   dbg_wdata, dbg_rdata;
    logic          mem_we, pipe_stall;
    logic [2:0]    mem_addr;
    logic [15:0]   mem_wdata, mem_rdata;
    logic [15:0]   mem [8];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    dmem_arbiter #(.DW(16), .AW(3), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_lock   (dbg_lock),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pipe_stall (pipe_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cpu(input logic req, input logic we, input logic [2:0] a, input logic [15:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic drive_dbg(input logic req, input logic we, input logic lock,
                             input logic [2:0] a, input logic [15:0] d);
        dbg_req = req; dbg_we = we; dbg_lock = lock; dbg_addr = a; dbg_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 16'h0;
        rst_n = 1'b0;
        drive_cpu(1'b1, 1'b1, 3'd3, 16'hA5A5);
        drive_dbg(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

        // Reset held with a pending CPU write.
        cycle();
        cycle();
        check("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
        check("rst_pipe_stall", 32'(pipe_stall), 32'd1);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_dbg_rdata",  32'(dbg_rdata),  32'd0);

        // Release: CPU write to addr 3 granted in the same cycle.
        rst_n = 1'b1;
        #1;
        check("rel_cpu_gnt",   32'(cpu_gnt),    32'd1);
        check("rel_stall",     32'(pipe_stall), 32'd0);
        check("wr_mem_we",     32'(mem_we),     32'd1);
        check("wr_mem_addr",   32'(mem_addr),   32'd3);
        cycle();
        check("wr_no_rvalid",  32'(cpu_rvalid), 32'd0);

        // CPU read of addr 3.
        drive_cpu(1'b1, 1'b0, 3'd3, 16'h0);
        #1;
        check("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
        cycle();
        drive_cpu(1'b0, 1'b0, 3'd0, 16'h0);
        check("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("rd_cpu_rdata",  32'(cpu_rdata),  32'hA5A5);
        check("rd_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        cycle();
        check("rd_rvalid_drop", 32'(cpu_rvalid), 32'd0);
        check("rd_rdata_hold",  32'(cpu_rdata),  32'hA5A5);

        // Starvation: both requesters held, expect CPU x4 then DBG, twice.
        drive_cpu(1'b1, 1'b0, 3'd3, 16'h0);
        drive_dbg(1'b1, 1'b1, 1'b0, 3'd7, 16'h7777);
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("starve_cpu_gnt_%0d", i), 32'(cpu_gnt),    32'((i % 5) != 4));
            check($sformatf("starve_dbg_gnt_%0d", i), 32'(dbg_gnt),    32'((i % 5) == 4));
            check($sformatf("starve_stall_%0d", i),   32'(pipe_stall), 32'((i % 5) == 4));
            cycle();
        end
        check("starve_mem7", 32'(mem[7]), 32'h7777);

        // Lock burst: four denied cycles raise the counter, then debug locks.
        drive_dbg(1'b1, 1'b1, 1'b1, 3'd0, 16'hD000);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("prelock_cpu_gnt_%0d", i), 32'(cpu_gnt), 32'd1);
            cycle();
        end
        for (int k = 0; k < 4; k++) begin
            drive_dbg(1'b1, 1'b1, (k < 3), 3'(k), 16'hD000 + 16'(k));
            #1;
            check($sformatf("lock_cpu_gnt_%0d", k), 32'(cpu_gnt),    32'd0);
            check($sformatf("lock_dbg_gnt_%0d", k), 32'(dbg_gnt),    32'd1);
            check($sformatf("lock_stall_%0d", k),   32'(pipe_stall), 32'd1);
            cycle();
        end
        drive_dbg(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        #1;
        check("unlock_cpu_gnt", 32'(cpu_gnt), 32'd1);
        cycle();
        for (int k = 0; k < 4; k++)
            check($sformatf("lock_mem_%0d", k), 32'(mem[k]), 32'hD000 + 32'(k));

        // Collision: debug write addr 5, CPU read addr 5 on the next cycle.
        drive_cpu(1'b0, 1'b0, 3'd0, 16'h0);
        drive_dbg(1'b1, 1'b1, 1'b0, 3'd5, 16'h1234);
        #1;
        check("col_dbg_gnt", 32'(dbg_gnt), 32'd1);
        cycle();
        drive_dbg(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        drive_cpu(1'b1, 1'b0, 3'd5, 16'h0);
        #1;
        check("col_cpu_gnt", 32'(cpu_gnt), 32'd1);
        cycle();
        drive_cpu(1'b0, 1'b0, 3'd0, 16'h0);
        check("col_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("col_cpu_rdata",  32'(cpu_rdata),  32'h1234);

        // Reset in the middle of a locked debug read.
        drive_dbg(1'b1, 1'b1, 1'b1, 3'd6, 16'hBEEF);
        cycle();
        drive_dbg(1'b1, 1'b0, 1'b1, 3'd6, 16'h0);
        drive_cpu(1'b1, 1'b0, 3'd1, 16'h0);
        #1;
        check("ml_dbg_gnt", 32'(dbg_gnt), 32'd1);
        check("ml_cpu_gnt", 32'(cpu_gnt), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("ml_rst_dbg_gnt", 32'(dbg_gnt),        32'd0);
        check("ml_rst_state",   32'(dut.state),      32'(ST_ARB));
        check("ml_rst_cnt",     32'(dut.starve_cnt), 32'd0);
        cycle();
        check("ml_no_rvalid", 32'(dbg_rvalid), 32'd0);
        rst_n = 1'b1;
        drive_dbg(1'b1, 1'b0, 1'b0, 3'd6, 16'h0);
        #1;
        check("ml_post_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("ml_post_dbg_gnt", 32'(dbg_gnt), 32'd0);
        cycle();
        check("ml_post_rvalid", 32'(dbg_rvalid),     32'd0);
        check("ml_post_cnt",    32'(dut.starve_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
